// File: rtl/clk_rst_sequencer.sv
// Clock/reset sequencer behind a PLL: drives the PLL reset, qualifies lock,
// releases the reset domains one after another, and makes per-domain clock enables.
module clk_rst_sequencer #(
  parameter int NUM_CH             = 6,
  parameter int DIV_W              = 8,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int STAGGER_CYCLES     = 16
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  output logic                    pll_rst,
  input  logic                    soft_rst_req,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  output logic [NUM_CH-1:0]       ch_rst_n,
  output logic [NUM_CH-1:0]       ch_ce,
  output logic                    ready,
  output logic                    lock_lost,
  output logic [7:0]              relock_cnt
);

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int REL_SPAN = (NUM_CH - 1) * STAGGER_CYCLES;
  localparam int TMR_W    = max_i(max_i($clog2(PLL_RST_CYCLES + 1), $clog2(LOCK_STABLE_CYCLES + 1)),
                                  max_i($clog2(LOCK_TIMEOUT + 1), $clog2(REL_SPAN + 1)));

  localparam logic [TMR_W-1:0] PRC_LAST = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] LSC_LAST = TMR_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] REL_LAST = TMR_W'(REL_SPAN);

  typedef enum logic [2:0] {
    PLLRST   = 3'd0,
    WAITLOCK = 3'd1,
    STABLE   = 3'd2,
    RELEASE  = 3'd3,
    RUN      = 3'd4
  } state_t;

  state_t             state;
  logic [TMR_W-1:0]   tmr;
  logic [TMR_W-1:0]   tmr_inc;
  logic               sync_q;
  logic               locked_s;
  logic               kill_all;
  logic [DIV_W-1:0]   div_cnt [NUM_CH];

  assign tmr_inc = tmr + TMR_W'(1);

  // Every channel drops on the coming edge; soft request wins over lock loss.
  assign kill_all = (soft_rst_req && (state != PLLRST)) ||
                    (!locked_s && ((state == RELEASE) || (state == RUN)));

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q   <= pll_locked;
      locked_s <= sync_q;
    end
  end

  // Sequencing FSM; one shared timer restarts on every state change.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PLLRST;
      tmr        <= '0;
      pll_rst    <= 1'b1;
      ch_rst_n   <= '0;
      ready      <= 1'b0;
      lock_lost  <= 1'b0;
      relock_cnt <= 8'd0;
    end else begin
      lock_lost <= 1'b0;
      if (soft_rst_req && (state != PLLRST)) begin
        state    <= PLLRST;
        tmr      <= '0;
        pll_rst  <= 1'b1;
        ch_rst_n <= '0;
        ready    <= 1'b0;
      end else begin
        case (state)
          PLLRST: begin
            if (tmr == PRC_LAST) begin
              state   <= WAITLOCK;
              tmr     <= '0;
              pll_rst <= 1'b0;
            end else begin
              tmr <= tmr_inc;
            end
          end
          WAITLOCK: begin
            if (locked_s) begin
              state <= STABLE;
              tmr   <= '0;
            end else if (tmr == TO_LAST) begin
              state   <= PLLRST;
              tmr     <= '0;
              pll_rst <= 1'b1;
            end else begin
              tmr <= tmr_inc;
            end
          end
          STABLE: begin
            if (!locked_s) begin
              state <= WAITLOCK;
              tmr   <= '0;
            end else if (tmr == LSC_LAST) begin
              ch_rst_n[0] <= 1'b1;
              tmr         <= '0;
              if (NUM_CH == 1) begin
                state <= RUN;
                ready <= 1'b1;
              end else begin
                state <= RELEASE;
              end
            end else begin
              tmr <= tmr_inc;
            end
          end
          RELEASE, RUN: begin
            if (!locked_s) begin
              // Lock dropped after release: back to waiting, PLL is not reset.
              state     <= WAITLOCK;
              tmr       <= '0;
              ch_rst_n  <= '0;
              ready     <= 1'b0;
              lock_lost <= 1'b1;
              if (relock_cnt != 8'hFF) begin
                relock_cnt <= relock_cnt + 8'd1;
              end
            end else if (state == RELEASE) begin
              for (int i = 1; i < NUM_CH; i++) begin
                if (TMR_W'(i * STAGGER_CYCLES) <= tmr_inc) begin
                  ch_rst_n[i] <= 1'b1;
                end
              end
              if (tmr_inc == REL_LAST) begin
                state <= RUN;
                ready <= 1'b1;
                tmr   <= '0;
              end else begin
                tmr <= tmr_inc;
              end
            end
          end
          default: begin
            state    <= PLLRST;
            tmr      <= '0;
            pll_rst  <= 1'b1;
            ch_rst_n <= '0;
            ready    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Per-channel dividers; >= compare lets a lowered div_val fire at once.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_cnt[i] <= '0;
      end
      ch_ce <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!ch_rst_n[i] || kill_all) begin
          div_cnt[i] <= '0;
          ch_ce[i]   <= 1'b0;
        end else if (div_cnt[i] >= div_val[i*DIV_W +: DIV_W]) begin
          div_cnt[i] <= '0;
          ch_ce[i]   <= 1'b1;
        end else begin
          div_cnt[i] <= div_cnt[i] + DIV_W'(1);
          ch_ce[i]   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Bench for clk_rst_sequencer: directed scenarios plus random lock/soft/divider
// traffic, every cycle compared with a phase/elapsed-time reference model.
module tb_clk_rst_sequencer;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 8;
  localparam int PRC    = 4;
  localparam int LSC    = 8;
  localparam int TO     = 32;
  localparam int STG    = 4;

  logic                    refclk       = 1'b0;
  logic                    rst_n        = 1'b0;
  logic                    pll_locked   = 1'b0;
  logic                    soft_rst_req = 1'b0;
  logic [NUM_CH*DIV_W-1:0] div_val      = '0;
  logic                    pll_rst;
  logic [NUM_CH-1:0]       ch_rst_n;
  logic [NUM_CH-1:0]       ch_ce;
  logic                    ready;
  logic                    lock_lost;
  logic [7:0]              relock_cnt;

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc_idx   = 0;
  int lost_seen = 0;

  clk_rst_sequencer #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .PLL_RST_CYCLES(PRC),
    .LOCK_STABLE_CYCLES(LSC), .LOCK_TIMEOUT(TO), .STAGGER_CYCLES(STG)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .soft_rst_req(soft_rst_req), .div_val(div_val), .ch_rst_n(ch_rst_n),
    .ch_ce(ch_ce), .ready(ready), .lock_lost(lock_lost), .relock_cnt(relock_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which phase we are in and how long we have been there.
  typedef enum int {M_PLLRST, M_WAIT, M_STABLE, M_REL, M_RUN} ph_t;
  ph_t               m_ph;
  int                m_el;
  logic              m_sync [2];
  int                m_relock;
  logic              m_lost;
  logic [NUM_CH-1:0] m_ce;
  int                m_cnt [NUM_CH];

  function automatic logic [NUM_CH-1:0] m_rel();
    logic [NUM_CH-1:0] r;
    for (int i = 0; i < NUM_CH; i++) r[i] = (m_ph == M_RUN) || (m_ph == M_REL && m_el >= i * STG);
    return r;
  endfunction

  task automatic model_reset();
    m_ph = M_PLLRST; m_el = 0; m_sync[0] = 1'b0; m_sync[1] = 1'b0;
    m_relock = 0; m_lost = 1'b0; m_ce = '0;
    for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
  endtask

  task automatic enter(input ph_t p);
    m_ph = p; m_el = 0;
  endtask

  task automatic model_step();
    logic ls;
    logic [NUM_CH-1:0] rel_old, rel_new;
    int dv;
    ls = m_sync[1];
    rel_old = m_rel();
    m_lost = 1'b0;
    if (soft_rst_req && m_ph != M_PLLRST) enter(M_PLLRST);
    else begin
      case (m_ph)
        M_PLLRST: if (m_el + 1 == PRC) enter(M_WAIT); else m_el++;
        M_WAIT:   if (ls) enter(M_STABLE); else if (m_el + 1 == TO) enter(M_PLLRST); else m_el++;
        M_STABLE: if (!ls) enter(M_WAIT); else if (m_el + 1 == LSC) enter(M_REL); else m_el++;
        default: begin
          if (!ls) begin
            enter(M_WAIT); m_lost = 1'b1;
            if (m_relock < 255) m_relock++;
          end else if (m_ph == M_REL) begin
            m_el++;
            if (m_el >= (NUM_CH - 1) * STG) enter(M_RUN);
          end
        end
      endcase
    end
    rel_new = m_rel();
    for (int i = 0; i < NUM_CH; i++) begin
      dv = int'(div_val[i*DIV_W +: DIV_W]);
      m_ce[i] = rel_old[i] && rel_new[i] && (m_cnt[i] >= dv);
      if (!rel_old[i] || !rel_new[i] || m_ce[i]) m_cnt[i] = 0; else m_cnt[i]++;
    end
    m_sync[1] = m_sync[0];
    m_sync[0] = pll_locked;
  endtask

  always @(posedge refclk) if (rst_n) model_step();
  always @(negedge rst_n) model_reset();

  task automatic compare_all();
    check_eq("pll_rst",    32'(pll_rst),    32'(m_ph == M_PLLRST));
    check_eq("ch_rst_n",   32'(ch_rst_n),   32'(m_rel()));
    check_eq("ch_ce",      32'(ch_ce),      32'(m_ce));
    check_eq("ready",      32'(ready),      32'(m_ph == M_RUN));
    check_eq("lock_lost",  32'(lock_lost),  32'(m_lost));
    check_eq("relock_cnt", 32'(relock_cnt), 32'(m_relock));
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge refclk);
      cyc_idx++;
      compare_all();
      if (lock_lost === 1'b1) lost_seen++;
    end
  endtask

  task automatic apply_reset(input string tag);
    @(negedge refclk);
    soft_rst_req = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq({tag, "_rst_pll_rst"}, 32'(pll_rst),    32'd1);
    check_eq({tag, "_rst_ch_rst_n"}, 32'(ch_rst_n),  32'd0);
    check_eq({tag, "_rst_ch_ce"},   32'(ch_ce),      32'd0);
    check_eq({tag, "_rst_ready"},   32'(ready),      32'd0);
    check_eq({tag, "_rst_relock"},  32'(relock_cnt), 32'd0);
    cyc(3);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int k = 0;
    while (ready !== 1'b1 && k < budget) begin
      cyc(1);
      k++;
    end
    check_eq(tag, 32'(ready), 32'd1);
  endtask

  initial begin
    int t_rise [NUM_CH];
    int t_rdy, t_lock, plen, found, lost0, cnt, k, t0;
    logic prev;
    int q1[$];
    int q2[$];
    int rises[$];

    model_reset();
    div_val = {8'd255, 8'd3, 8'd0};

    // Power-up
    pll_locked = 1'b0;
    apply_reset("por");
    plen = int'(pll_rst);
    for (int j = 0; j < 9; j++) begin
      cyc(1);
      plen += int'(pll_rst);
    end
    check_eq("por_pll_rst_len", 32'(plen), 32'(PRC));
    pll_locked = 1'b1;
    t_lock = cyc_idx;
    for (int i = 0; i < NUM_CH; i++) t_rise[i] = -1;
    t_rdy = -1;
    for (int j = 0; j < 80 && t_rdy < 0; j++) begin
      cyc(1);
      for (int i = 0; i < NUM_CH; i++) if (ch_rst_n[i] && t_rise[i] < 0) t_rise[i] = cyc_idx;
      if (ready && t_rdy < 0) t_rdy = cyc_idx;
    end
    check_eq("por_ready_seen", 32'(t_rdy >= 0), 32'd1);
    check_eq("por_release_lat", 32'(t_rise[0] - t_lock), 32'(3 + LSC));
    for (int i = 1; i < NUM_CH; i++) check_eq("por_stagger", 32'(t_rise[i] - t_rise[i-1]), 32'(STG));
    check_eq("por_ready_with_last", 32'(t_rdy), 32'(t_rise[NUM_CH-1]));
    check_eq("por_relock", 32'(relock_cnt), 32'd0);

    // Dividers {0,3,255}
    cnt = 0;
    for (int j = 0; j < 600; j++) begin
      cyc(1);
      if (!ch_ce[0]) cnt++;
      if (ch_ce[1]) q1.push_back(cyc_idx);
      if (ch_ce[2]) q2.push_back(cyc_idx);
    end
    check_eq("ce0_always_high", 32'(cnt), 32'd0);
    check_eq("ce1_enough", 32'(q1.size() >= 2), 32'd1);
    if (q1.size() >= 2) check_eq("ce1_period", 32'(q1[1] - q1[0]), 32'd4);
    check_eq("ce2_enough", 32'(q2.size() >= 2), 32'd1);
    if (q2.size() >= 2) check_eq("ce2_period", 32'(q2[1] - q2[0]), 32'd256);
    k = 0;
    while (ch_ce[2] !== 1'b1 && k < 300) begin cyc(1); k++; end
    check_eq("ce2_pulse_seen", 32'(ch_ce[2]), 32'd1);
    cyc(50);
    div_val[2*DIV_W +: DIV_W] = 8'd2;
    cyc(1);
    check_eq("ce2_after_lower", 32'(ch_ce[2]), 32'd1);
    t0 = cyc_idx;
    q2.delete();
    for (int j = 0; j < 7; j++) begin
      cyc(1);
      if (ch_ce[2]) q2.push_back(cyc_idx);
    end
    check_eq("ce2_new_count", 32'(q2.size()), 32'd2);
    if (q2.size() >= 1) check_eq("ce2_new_period", 32'(q2[0] - t0), 32'd3);

    // Lock loss in RUN
    cyc($urandom_range(1, 20));
    lost0 = lost_seen;
    pll_locked = 1'b0;
    found = -1;
    for (int j = 1; j <= 3; j++) begin
      cyc(1);
      if (ch_rst_n == '0 && ready == 1'b0 && found < 0) found = j;
    end
    check_eq("loss_latency_le3", 32'(found >= 1 && found <= 3), 32'd1);
    cyc(4);
    check_eq("loss_pulses", 32'(lost_seen - lost0), 32'd1);
    check_eq("loss_relock", 32'(relock_cnt), 32'd1);
    pll_locked = 1'b1;
    cnt = 0; k = 0;
    while (ready !== 1'b1 && k < 100) begin
      cyc(1); k++;
      if (pll_rst) cnt++;
    end
    check_eq("relock_no_pll_rst", 32'(cnt), 32'd0);
    check_eq("relock_ready", 32'(ready), 32'd1);

    // Soft request during RELEASE, same cycle as lock loss
    pll_locked = 1'b0;
    cyc(6);
    check_eq("second_loss_relock", 32'(relock_cnt), 32'd2);
    pll_locked = 1'b1;
    k = 0;
    while (ch_rst_n[0] !== 1'b1 && k < 60) begin cyc(1); k++; end
    check_eq("soft_in_release", 32'(ready), 32'd0);
    pll_locked = 1'b0;
    cyc(2);
    soft_rst_req = 1'b1;
    cyc(1);
    soft_rst_req = 1'b0;
    check_eq("soft_pll_rst", 32'(pll_rst), 32'd1);
    check_eq("soft_ch_rst_n", 32'(ch_rst_n), 32'd0);
    check_eq("soft_no_lost", 32'(lock_lost), 32'd0);
    check_eq("soft_relock_kept", 32'(relock_cnt), 32'd2);
    pll_locked = 1'b1;
    plen = int'(pll_rst); k = 0;
    while (pll_rst === 1'b1 && k < 20) begin cyc(1); k++; plen += int'(pll_rst); end
    check_eq("soft_pll_rst_len", 32'(plen), 32'(PRC));
    wait_ready("soft_ready", 100);

    // Glitchy lock (reset applied from RUN)
    apply_reset("glitch");
    cyc(PRC);
    lost0 = lost_seen;
    pll_locked = 1'b1; cyc(5);
    pll_locked = 1'b0; cyc(1);
    pll_locked = 1'b1;
    t0 = cyc_idx; k = 0;
    while (ch_rst_n[0] !== 1'b1 && k < 40) begin cyc(1); k++; end
    check_eq("glitch_release_lat", 32'(cyc_idx - t0), 32'(3 + LSC));
    wait_ready("glitch_ready", 40);
    check_eq("glitch_no_lost", 32'(lost_seen - lost0), 32'd0);

    // Timeout
    pll_locked = 1'b0;
    apply_reset("tmo");
    t0 = cyc_idx;
    prev = pll_rst;
    for (int j = 0; j < 120; j++) begin
      cyc(1);
      if (pll_rst && !prev) rises.push_back(cyc_idx);
      prev = pll_rst;
    end
    check_eq("tmo_rise_count", 32'(rises.size()), 32'd3);
    if (rises.size() >= 1) check_eq("tmo_first", 32'(rises[0] - t0), 32'(PRC + TO));
    for (int j = 1; j < rises.size(); j++) check_eq("tmo_period", 32'(rises[j] - rises[j-1]), 32'(PRC + TO));

    // relock_cnt saturation
    apply_reset("sat");
    cyc(PRC);
    for (int j = 0; j < 262; j++) begin
      pll_locked = 1'b1; cyc(14);
      pll_locked = 1'b0; cyc(2);
    end
    cyc(4);
    check_eq("relock_saturated", 32'(relock_cnt), 32'd255);

    // Random traffic
    apply_reset("rnd");
    for (int j = 0; j < 1500; j++) begin
      soft_rst_req = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) pll_locked = ~pll_locked;
      if ($urandom_range(0, 49) == 0) div_val[$urandom_range(0, NUM_CH-1)*DIV_W +: DIV_W] = 8'($urandom_range(0, 7));
      cyc(1);
    end
    soft_rst_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
